// File: rtl/utlb_mmu_pkg.sv
// mmu_pkg: shared uTLB entry type, exception codes, FSM states and segment decode
package mmu_pkg;
  localparam logic [1:0] EX_NONE    = 2'b00;
  localparam logic [1:0] EX_REFILL  = 2'b01;
  localparam logic [1:0] EX_INVALID = 2'b10;
  localparam logic [1:0] EX_MOD     = 2'b11;
  typedef struct packed {
    logic        valid;
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic        d;
    logic        v;
  } utlb_ent_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_RESP} state_e;
  function automatic logic is_unmapped(input logic [31:0] a);
    return a[31:30] == 2'b10;
  endfunction
endpackage

// File: rtl/utlb_mmu_if.sv
// utlb_mmu_if: pipeline request/response bundle and joint-TLB search bundle
interface utlb_req_if;
  logic        req_valid, req_store, req_ready, resp_valid, resp_uncached;
  logic [31:0] req_vaddr, resp_paddr;
  logic [1:0]  resp_ex;
  modport master(output req_valid, req_vaddr, req_store,
                 input req_ready, resp_valid, resp_paddr, resp_uncached, resp_ex);
  modport slave(input req_valid, req_vaddr, req_store,
                output req_ready, resp_valid, resp_paddr, resp_uncached, resp_ex);
endinterface

interface jtlb_if #(parameter int VPN2_W = 19, parameter int PFN_W = 20);
  logic              s_req, s_ready, s_found, s_d, s_v, s_odd_page;
  logic [VPN2_W-1:0] s_vpn2;
  logic [PFN_W-1:0]  s_pfn;
  modport master(output s_req, s_vpn2, s_odd_page, input s_ready, s_found, s_pfn, s_d, s_v);
  modport slave(input s_req, s_vpn2, s_odd_page, output s_ready, s_found, s_pfn, s_d, s_v);
endinterface

// File: rtl/utlb_mmu_cam.sv
// utlb_cam: fully-associative uTLB storage with parallel match, victim select and flush
module utlb_cam import mmu_pkg::*; #(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_flush,
  input  logic [19:0] i_vpn,
  input  logic      i_fill,
  input  utlb_ent_t i_fill_ent,
  output logic      o_hit,
  output utlb_ent_t o_ent
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  utlb_ent_t r_ent [N];
  logic [PW-1:0] r_ptr, w_inv_idx, w_vic;
  logic w_any_inv;
  always_comb begin
    o_hit = 1'b0;
    o_ent = '0;
    w_any_inv = 1'b0;
    w_inv_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_ent[i].valid && r_ent[i].vpn == i_vpn) begin
        o_hit = 1'b1;
        o_ent = o_ent | r_ent[i];
      end
      if (!r_ent[i].valid) begin
        w_any_inv = 1'b1;
        w_inv_idx = PW'(i);
      end
    end
  end
  assign w_vic = w_any_inv ? w_inv_idx : r_ptr;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      for (int i = 0; i < N; i++) r_ent[i].valid <= 1'b0;
    end else if (i_flush) begin
      for (int i = 0; i < N; i++) r_ent[i].valid <= 1'b0;
    end else if (i_fill) begin
      r_ent[w_vic] <= i_fill_ent;
      if (!w_any_inv) r_ptr <= r_ptr + PW'(1);
    end
  end
endmodule

// File: rtl/utlb_mmu.sv
// utlb_mmu: address translation through a uTLB with joint-TLB walk on miss
module utlb_mmu import mmu_pkg::*; #(
  parameter int UTLB_ENTRIES = 4,
  parameter int IS_DATA      = 0,
  parameter int VPN2_W       = 19,
  parameter int PFN_W        = 20
) (
  input logic       clk,
  input logic       reset,
  input logic       i_flush,
  utlb_req_if.slave p_req,
  jtlb_if.master    p_jt
);
  state_e r_state, w_state_n;
  logic [31:0] r_vaddr, r_paddr;
  logic r_store, r_pend, r_rv, r_unc;
  logic [1:0] r_ex, w_ex;
  logic w_acc, w_unm, w_hit, w_lk_hit, w_miss, w_done, w_fill, w_st;
  logic [11:0] w_off;
  utlb_ent_t w_ent, w_fill_ent, w_src;
  utlb_cam #(.N(UTLB_ENTRIES)) u_cam (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (i_flush),
    .i_vpn      (p_req.req_vaddr[31:12]),
    .i_fill     (w_fill),
    .i_fill_ent (w_fill_ent),
    .o_hit      (w_hit),
    .o_ent      (w_ent)
  );
  assign w_acc      = p_req.req_valid && r_state == ST_IDLE;
  assign w_unm      = is_unmapped(p_req.req_vaddr);
  assign w_lk_hit   = w_acc && !w_unm && w_hit && !i_flush;
  assign w_miss     = w_acc && !w_unm && !w_lk_hit;
  assign w_done     = r_state == ST_WALK && p_jt.s_ready;
  assign w_fill_ent = '{valid: 1'b1, vpn: r_vaddr[31:12], pfn: 20'(p_jt.s_pfn), d: p_jt.s_d, v: p_jt.s_v};
  assign w_fill     = w_done && p_jt.s_found && !r_pend;
  assign w_src      = w_done ? w_fill_ent : w_ent;
  assign w_off      = w_done ? r_vaddr[11:0] : p_req.req_vaddr[11:0];
  assign w_st       = IS_DATA != 0 && (w_done ? r_store : p_req.req_store);
  assign w_ex       = (w_done && !p_jt.s_found) ? EX_REFILL :
                      !w_src.v ? EX_INVALID :
                      (w_st && !w_src.d) ? EX_MOD : EX_NONE;
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_n;
  end
  always_comb begin
    w_state_n = r_state;
    w_state_n = r_state == ST_IDLE ? (w_miss ? ST_WALK : ST_IDLE) :
                r_state == ST_WALK ? (p_jt.s_ready ? ST_RESP : ST_WALK) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rv    <= 1'b0;
      r_paddr <= '0;
      r_unc   <= 1'b0;
      r_ex    <= EX_NONE;
      r_pend  <= 1'b0;
      r_vaddr <= '0;
      r_store <= 1'b0;
    end else begin
      r_rv <= (w_acc && (w_unm || w_lk_hit)) || w_done;
      if (w_acc && w_unm) begin
        r_paddr <= {3'b000, p_req.req_vaddr[28:0]};
        r_unc   <= p_req.req_vaddr[29];
        r_ex    <= EX_NONE;
      end else if (w_lk_hit || w_done) begin
        r_paddr <= (w_done && !p_jt.s_found) ? '0 : {w_src.pfn, w_off};
        r_unc   <= 1'b0;
        r_ex    <= w_ex;
      end
      if (w_miss) begin
        r_vaddr <= p_req.req_vaddr;
        r_store <= p_req.req_store;
      end
      r_pend <= r_state == ST_RESP ? 1'b0 : r_pend || (r_state == ST_WALK && i_flush);
    end
  end
  assign p_req.req_ready     = r_state == ST_IDLE;
  assign p_req.resp_valid    = r_rv;
  assign p_req.resp_paddr    = r_paddr;
  assign p_req.resp_uncached = r_unc;
  assign p_req.resp_ex       = r_ex;
  assign p_jt.s_req          = r_state == ST_WALK;
  assign p_jt.s_vpn2         = VPN2_W'(r_vaddr[31:13]);
  assign p_jt.s_odd_page     = r_vaddr[12];
endmodule

// File: tb/tb_utlb_mmu.sv
// tb_utlb_mmu: directed checks of segment bypass, uTLB hit/miss, fill, eviction, flush and reset
module tb_utlb_mmu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_flush = 1'b0;
  int n_tot = 0;
  int n_bad = 0;
  logic g_walk, g_rv, g_unc, g_stall;
  logic [31:0] g_pa;
  logic [1:0] g_ex;
  utlb_req_if u_req ();
  jtlb_if #(.VPN2_W(19), .PFN_W(20)) u_jt ();
  utlb_mmu #(.UTLB_ENTRIES(4), .IS_DATA(1), .VPN2_W(19), .PFN_W(20)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_flush (i_flush),
    .p_req   (u_req),
    .p_jt    (u_jt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic acc(input logic [31:0] va, input logic st, input logic fnd, input logic [19:0] pfn,
                     input logic d, input logic v, input int stall, input int fl);
    @(negedge clk);
    u_req.req_valid = 1'b1;
    u_req.req_vaddr = va;
    u_req.req_store = st;
    i_flush = fl == 2;
    @(negedge clk);
    u_req.req_valid = 1'b0;
    i_flush = 1'b0;
    g_walk = u_jt.s_req;
    g_stall = 1'b1;
    if (u_jt.s_req) begin
      if (fl == 1) begin
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
      end
      repeat (stall) begin
        @(negedge clk);
        g_stall = g_stall && u_jt.s_req && !u_req.req_ready;
      end
      u_jt.s_ready = 1'b1;
      u_jt.s_found = fnd;
      u_jt.s_pfn = pfn;
      u_jt.s_d = d;
      u_jt.s_v = v;
      @(negedge clk);
      u_jt.s_ready = 1'b0;
    end
    g_rv = u_req.resp_valid;
    g_pa = u_req.resp_paddr;
    g_ex = u_req.resp_ex;
    g_unc = u_req.resp_uncached;
  endtask
  task automatic flush_pulse();
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask
  initial begin
    u_req.req_valid = 1'b0;
    u_req.req_vaddr = '0;
    u_req.req_store = 1'b0;
    u_jt.s_ready = 1'b0;
    u_jt.s_found = 1'b0;
    u_jt.s_pfn = '0;
    u_jt.s_d = 1'b0;
    u_jt.s_v = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(u_req.req_ready), 1);
    chk("rst_rv", 32'(u_req.resp_valid), 0);
    chk("rst_pa", u_req.resp_paddr, 0);
    chk("rst_ex", 32'(u_req.resp_ex), 0);
    chk("rst_sreq", 32'(u_jt.s_req), 0);
    acc(32'hA000_1234, 0, 0, 0, 0, 0, 0, 0);
    chk("k1_walk", 32'(g_walk), 0);
    chk("k1_rv", 32'(g_rv), 1);
    chk("k1_pa", g_pa, 32'h0000_1234);
    chk("k1_unc", 32'(g_unc), 1);
    chk("k1_ex", 32'(g_ex), 0);
    acc(32'h8FFF_F000, 0, 0, 0, 0, 0, 0, 0);
    chk("k0_walk", 32'(g_walk), 0);
    chk("k0_pa", g_pa, 32'h0FFF_F000);
    chk("k0_unc", 32'(g_unc), 0);
    acc(32'h0040_0010, 0, 1, 20'h12345, 1, 1, 0, 0);
    chk("miss_walk", 32'(g_walk), 1);
    chk("miss_rv", 32'(g_rv), 1);
    chk("miss_pa", g_pa, 32'h1234_5010);
    chk("miss_ex", 32'(g_ex), 0);
    acc(32'h0040_0FFC, 0, 0, 0, 0, 0, 0, 0);
    chk("hit_walk", 32'(g_walk), 0);
    chk("hit_rv", 32'(g_rv), 1);
    chk("hit_pa", g_pa, 32'h1234_5FFC);
    acc(32'h0050_0000, 0, 0, 0, 0, 0, 0, 0);
    chk("nf_ex", 32'(g_ex), 1);
    chk("nf_pa", g_pa, 0);
    acc(32'h0050_0000, 0, 0, 0, 0, 0, 0, 0);
    chk("nf_rewalk", 32'(g_walk), 1);
    chk("nf_ex2", 32'(g_ex), 1);
    acc(32'h0060_0008, 0, 1, 20'h00ABC, 0, 0, 0, 0);
    chk("inv_ex", 32'(g_ex), 2);
    acc(32'h0060_0008, 0, 0, 0, 0, 0, 0, 0);
    chk("inv_hit_walk", 32'(g_walk), 0);
    chk("inv_hit_ex", 32'(g_ex), 2);
    acc(32'h0070_0000, 1, 1, 20'h00777, 0, 1, 0, 0);
    chk("mod_miss_ex", 32'(g_ex), 3);
    acc(32'h0070_0010, 1, 0, 0, 0, 0, 0, 0);
    chk("mod_hit_walk", 32'(g_walk), 0);
    chk("mod_hit_ex", 32'(g_ex), 3);
    acc(32'h0070_0004, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_ex", 32'(g_ex), 0);
    chk("ld_pa", g_pa, 32'h0077_7004);
    acc(32'h0040_0020, 1, 0, 0, 0, 0, 0, 0);
    chk("st_dirty_ex", 32'(g_ex), 0);
    flush_pulse();
    for (int k = 1; k <= 5; k++) begin
      acc(32'h0100_0000 + 32'(k) * 32'h1000, 0, 1, 20'h00100 + 20'(k), 1, 1, k == 5 ? 3 : 0, 0);
      chk($sformatf("fill%0d_walk", k), 32'(g_walk), 1);
      chk($sformatf("fill%0d_pa", k), g_pa, {20'h00100 + 20'(k), 12'h000});
    end
    chk("stall_hold", 32'(g_stall), 1);
    for (int k = 2; k <= 5; k++) begin
      acc(32'h0100_0000 + 32'(k) * 32'h1000, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("keep%0d_walk", k), 32'(g_walk), 0);
      chk($sformatf("keep%0d_pa", k), g_pa, {20'h00100 + 20'(k), 12'h000});
    end
    acc(32'h0100_1000, 0, 1, 20'h00101, 1, 1, 0, 0);
    chk("evict1_walk", 32'(g_walk), 1);
    acc(32'h0200_0000, 0, 1, 20'h00200, 1, 1, 1, 1);
    chk("flw_rv", 32'(g_rv), 1);
    chk("flw_pa", g_pa, 32'h0020_0000);
    chk("flw_ex", 32'(g_ex), 0);
    acc(32'h0100_3000, 0, 1, 20'h00103, 1, 1, 0, 0);
    chk("flw_old_walk", 32'(g_walk), 1);
    acc(32'h0200_0000, 0, 1, 20'h00200, 1, 1, 0, 0);
    chk("flw_nofill_walk", 32'(g_walk), 1);
    acc(32'h0200_0004, 0, 0, 0, 0, 0, 0, 0);
    chk("refill_hit_walk", 32'(g_walk), 0);
    acc(32'h0200_0008, 0, 1, 20'h00200, 1, 1, 0, 2);
    chk("flacc_walk", 32'(g_walk), 1);
    chk("flacc_pa", g_pa, 32'h0020_0008);
    @(negedge clk);
    u_req.req_valid = 1'b1;
    u_req.req_vaddr = 32'h0300_0000;
    @(negedge clk);
    u_req.req_valid = 1'b0;
    chk("rw_sreq", 32'(u_jt.s_req), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_sreq_drop", 32'(u_jt.s_req), 0);
    chk("rw_ready", 32'(u_req.req_ready), 1);
    chk("rw_rv", 32'(u_req.resp_valid), 0);
    repeat (2) @(negedge clk);
    chk("rw_rv_later", 32'(u_req.resp_valid), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
